regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
Shares the register file's single write port (WriteRegister/WriteData/RegWrite) between NREQ requesters using round-robin arbitration with a valid/ready handshake. After reset, or on ClearReq, it first sweeps every register to zero, because the register file has no reset of its own. It sits between the execute/writeback sources and the register file, and drives the register file's write port directly.

Parameters:
NREQ, 4, number of write requesters (2..8)
AW, 5, register address width
DW, 32, write data width
NREGS, 32, number of registers cleared by the sweep (must be ≤ 2**AW)
ZERO_PROTECT, 1, when 1, writes to address 0 are accepted but never issued

Ports:
Clk  input  1  clock; all state updates on the rising edge
Rst_n  input  1  asynchronous active-low reset
Req  input  NREQ  per-requester write valid
ReqAddr  input  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW]
ReqData  input  NREQ*DW  packed data; requester i uses bits [i*DW +: DW]
Grant  output  NREQ  one-hot ready; a transfer happens when Req[i] and Grant[i] are both 1
ClearReq  input  1  single-cycle pulse that restarts the zero sweep
WriteRegister  output  AW  to the register file
WriteData  output  DW  to the register file
RegWrite  output  1  to the register file
InitDone  output  1  high once the sweep has completed
Busy  output  1  high while sweeping

Behaviour:
- Reset (asynchronous, Rst_n=0):
  - state = CLEAR, sweep counter = 0, round-robin pointer = 0.
  - RegWrite=0, WriteRegister=0, WriteData=0, Grant=0, InitDone=0, Busy=1.
- FSM states: CLEAR, ARB.
- CLEAR:
  - Each cycle registers RegWrite=1, WriteRegister=counter, WriteData=0, then increments the counter.
  - The cycle after the write to NREGS-1 is issued, the state becomes ARB and InitDone=1.
  - Grant=0 throughout CLEAR.
  - The sweep takes exactly NREGS cycles from reset release to the last write.
- ARB:
  - Grant is combinational from Req and the pointer.
  - Search order is ptr, ptr+1, … NREQ-1, 0, … (wraps modulo NREQ); the first requester with Req=1 gets Grant=1.
  - Grant is always one-hot or zero.
  - On a transfer by requester g, the pointer becomes (g+1) mod NREQ.
  - Latency: a transfer in cycle t produces registered outputs in cycle t+1 (RegWrite=1, WriteRegister=ReqAddr[g], WriteData=ReqData[g]). The register file commits the write on the following posedge.
  - Throughput is one write per cycle. With no transfer, RegWrite=0 next cycle; WriteRegister and WriteData hold their last values.
- ZERO_PROTECT=1 and the granted address is 0: the handshake completes and the pointer advances, but RegWrite=0 next cycle.
- ClearReq in ARB:
  - Takes priority over arbitration in that same cycle: Grant=0, nothing is accepted.
  - Next state is CLEAR with counter=0, InitDone=0, Busy=1.
  - A write already registered in the output stage still completes.
- ClearReq during CLEAR restarts the counter at 0.
- Reset asserted mid-sweep or mid-transfer: immediate return to reset values; a partially swept file is swept again from 0.
- Requesters must hold Req, ReqAddr and ReqData stable until granted. Dropping Req before Grant is allowed and nothing is written.
- Pointer wrap: after a grant to NREQ-1, the pointer is 0.
- No same-address merging: back-to-back writes to one address both issue, in order.

Decomposition:
- Shared package regfile_pkg: AW, DW, NREGS constants; state encoding localparams ST_CLEAR=1'b0, ST_ARB=1'b1.
- One natural sub-module: rr_arbiter (NREQ), a combinational one-hot grant from Req and the pointer, plus pointer update on accept. This can be reused by later read-port sharing.
- Output register stage and FSM stay in the top module.

Test Plan:
- Reset release with NREGS=32 -> RegWrite=1 for 32 consecutive cycles, WriteRegister 0..31, WriteData=0; then InitDone=1, Busy=0. The register file reads 0 at every address.
- After init, Req=4'b1111 held with ReqAddr[i]=i+1 and ReqData[i]=32'hA0+i -> Grant sequence 0001, 0010, 0100, 1000, 0001. Writes land at r1..r4 with A0..A3, one per cycle, each 1 cycle after its grant.
- After a grant to requester 1, Req=4'b0101 -> requester 2 granted next, then requester 0 (wrap), then 2.
- ZERO_PROTECT=1, single requester writes addr 0 data 32'hDEADBEEF -> Grant=1, RegWrite stays 0, r0 reads 0. The same write to addr 5 -> r5 = DEADBEEF.
- ClearReq pulsed while Req=4'b0011 -> Grant=0 that cycle, a full 32-cycle sweep follows, then arbitration resumes from the unchanged pointer.
- Rst_n pulsed low at sweep cycle 10 -> outputs return to reset values immediately, and the sweep restarts at address 0 after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the register-file write arbiter.
// Also hosts the pointer-width helper used by the round-robin arbiter.
package regfile_pkg;

  localparam int RF_NREQ  = 4;
  localparam int RF_AW    = 5;
  localparam int RF_DW    = 32;
  localparam int RF_NREGS = 32;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_ARB   = 1'b1
  } state_t;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr.sv
// Round-robin one-hot grant with a rotating priority pointer.
// The pointer moves past the winner whenever a grant is accepted.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter  int NREQ = RF_NREQ,
  localparam int PW   = ptr_w(NREQ)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_en,
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_grant,
  output logic [PW-1:0]   o_idx,
  output logic            o_accept
);

  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   w_pos;
  logic [PW-1:0]   w_idx;
  logic [PW-1:0]   w_nxt;
  logic [NREQ-1:0] w_grant;
  logic            w_found;

  always_comb begin
    w_grant = '0;
    w_idx   = r_ptr;
    w_found = 1'b0;
    w_pos   = r_ptr;
    for (int k = 0; k < NREQ; k++) begin
      w_pos = PW'((int'(r_ptr) + k) % NREQ);
      if (i_en && !w_found && i_req[w_pos]) begin
        w_grant[w_pos] = 1'b1;
        w_idx          = w_pos;
        w_found        = 1'b1;
      end
    end
  end

  assign w_nxt = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + PW'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= w_nxt;
    end
  end

  assign o_grant  = w_grant;
  assign o_idx    = w_idx;
  assign o_accept = w_found;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between NREQ requesters.
// Sweeps every register to zero after reset or a clear request.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter  int NREQ         = RF_NREQ,
  parameter  int AW           = RF_AW,
  parameter  int DW           = RF_DW,
  parameter  int NREGS        = RF_NREGS,
  parameter  int ZERO_PROTECT = 1,
  localparam int PW           = ptr_w(NREQ)
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [NREQ-1:0]    Req,
  input  logic [NREQ*AW-1:0] ReqAddr,
  input  logic [NREQ*DW-1:0] ReqData,
  output logic [NREQ-1:0]    Grant,
  input  logic               ClearReq,
  output logic [AW-1:0]      WriteRegister,
  output logic [DW-1:0]      WriteData,
  output logic               RegWrite,
  output logic               InitDone,
  output logic               Busy
);

  state_t          r_state;
  state_t          w_state_nx;
  logic [AW-1:0]   r_cnt;
  logic [AW-1:0]   w_cnt_nx;
  logic            w_clr_wr;
  logic            w_arb_en;
  logic            w_accept;
  logic            w_issue;
  logic [PW-1:0]   w_idx;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_data;
  logic            r_we;
  logic [AW-1:0]   r_waddr;
  logic [DW-1:0]   r_wdata;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_clr_wr   = 1'b0;
    w_arb_en   = 1'b0;
    unique case (r_state)
      ST_CLEAR: begin
        if (ClearReq) begin
          w_cnt_nx = '0;
        end else begin
          w_clr_wr = 1'b1;
          w_cnt_nx = r_cnt + AW'(1);
          if (r_cnt == AW'(NREGS - 1)) begin
            w_state_nx = ST_ARB;
            w_cnt_nx   = '0;
          end
        end
      end
      ST_ARB: begin
        if (ClearReq) begin
          w_state_nx = ST_CLEAR;
          w_cnt_nx   = '0;
        end else begin
          w_arb_en = 1'b1;
        end
      end
      default: begin
        w_state_nx = ST_CLEAR;
        w_cnt_nx   = '0;
      end
    endcase
  end

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr (
    .i_clk   (Clk),
    .i_rst_n (Rst_n),
    .i_en    (w_arb_en),
    .i_req   (Req),
    .o_grant (Grant),
    .o_idx   (w_idx),
    .o_accept(w_accept)
  );

  assign w_sel_addr = ReqAddr[int'(w_idx)*AW +: AW];
  assign w_sel_data = ReqData[int'(w_idx)*DW +: DW];

  // A protected address-0 write is accepted but leaves the port idle.
  assign w_issue = w_accept &&
                   !((ZERO_PROTECT != 0) && (w_sel_addr == '0));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_clr_wr | w_issue;
      if (w_clr_wr) begin
        r_waddr <= r_cnt;
        r_wdata <= '0;
      end else if (w_issue) begin
        r_waddr <= w_sel_addr;
        r_wdata <= w_sel_data;
      end
    end
  end

  assign RegWrite      = r_we;
  assign WriteRegister = r_waddr;
  assign WriteData     = r_wdata;
  assign InitDone      = (r_state == ST_ARB);
  assign Busy          = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: scenario tasks against a round-robin reference
// model and a behavioural register file fed by the write port.
module tb_regfile_write_arbiter;

  localparam int NREQ  = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NREGS = 32;

  logic               Clk;
  logic               Rst_n;
  logic [NREQ-1:0]    Req;
  logic [NREQ*AW-1:0] ReqAddr;
  logic [NREQ*DW-1:0] ReqData;
  logic [NREQ-1:0]    Grant;
  logic               ClearReq;
  logic [AW-1:0]      WriteRegister;
  logic [DW-1:0]      WriteData;
  logic               RegWrite;
  logic               InitDone;
  logic               Busy;

  logic [DW-1:0] rf   [2**AW];
  logic [DW-1:0] m_rf [2**AW];
  int            checks;
  int            failures;
  int            m_ptr;
  logic [AW-1:0] m_last_addr;
  logic [DW-1:0] m_last_data;

  regfile_write_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW),
    .NREGS(NREGS), .ZERO_PROTECT(1)
  ) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .Req          (Req),
    .ReqAddr      (ReqAddr),
    .ReqData      (ReqData),
    .Grant        (Grant),
    .ClearReq     (ClearReq),
    .WriteRegister(WriteRegister),
    .WriteData    (WriteData),
    .RegWrite     (RegWrite),
    .InitDone     (InitDone),
    .Busy         (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (RegWrite) rf[WriteRegister] <= WriteData;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic int model_pick(input logic [NREQ-1:0] req,
                                    input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (req[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int g);
    logic [NREQ-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    ReqAddr[i*AW +: AW] = a;
    ReqData[i*DW +: DW] = d;
  endtask

  task automatic test_reset;
    Rst_n = 1'b0; Req = '0; ClearReq = 1'b0;
    ReqAddr = '0; ReqData = '0;
    tick;
    checks++;
    if (RegWrite !== 1'b0 || WriteRegister !== '0 || WriteData !== '0 ||
        Grant !== '0 || InitDone !== 1'b0 || Busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_vals: got we=%b a=%0d d=%h g=%b id=%b b=%b exp 0 0 0 0 0 1",
               RegWrite, WriteRegister, WriteData, Grant, InitDone, Busy);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int k = 0; k < NREGS; k++) begin
      tick;
      checks++;
      if (RegWrite !== 1'b1 || WriteRegister !== AW'(k) || WriteData !== '0) begin
        failures++;
        $display("FAIL sweep_%0d: got we=%b a=%0d d=%h exp 1 %0d 0",
                 k, RegWrite, WriteRegister, WriteData, k);
      end
      if (k < NREGS - 1) begin
        checks++;
        if (Busy !== 1'b1 || Grant !== '0 || InitDone !== 1'b0) begin
          failures++;
          $display("FAIL sweep_busy_%0d: got b=%b g=%b id=%b exp 1 0 0",
                   k, Busy, Grant, InitDone);
        end
      end
    end
    tick;
    checks++;
    if (RegWrite !== 1'b0 || InitDone !== 1'b1 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL init_done: got we=%b id=%b b=%b exp 0 1 0",
               RegWrite, InitDone, Busy);
    end
    for (int a = 0; a < NREGS; a++) begin
      checks++;
      if (rf[a] !== '0) begin
        failures++;
        $display("FAIL rf_zero_%0d: got %h exp 0", a, rf[a]);
      end
    end
    m_ptr = 0;
    m_last_addr = AW'(NREGS - 1);
    m_last_data = '0;
  endtask

  task automatic test_all_req;
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    Req = '1;
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), DW'(32'hA0 + i));
    for (int n = 0; n < 5; n++) begin
      #1;
      checks++;
      if (Grant !== onehot(exp_seq[n])) begin
        failures++;
        $display("FAIL all_grant_%0d: got %b exp %b", n, Grant, onehot(exp_seq[n]));
      end
      m_ptr = (exp_seq[n] + 1) % NREQ;
      tick;
      checks++;
      if (RegWrite !== 1'b1 || WriteRegister !== AW'(exp_seq[n] + 1) ||
          WriteData !== DW'(32'hA0 + exp_seq[n])) begin
        failures++;
        $display("FAIL all_write_%0d: got we=%b a=%0d d=%h exp 1 %0d %h",
                 n, RegWrite, WriteRegister, WriteData,
                 exp_seq[n] + 1, 32'hA0 + exp_seq[n]);
      end
    end
    m_last_addr = 5'd1; m_last_data = 32'hA0;
    Req = '0;
    tick;
    checks++;
    if (RegWrite !== 1'b0 || WriteRegister !== m_last_addr ||
        WriteData !== m_last_data) begin
      failures++;
      $display("FAIL idle_hold: got we=%b a=%0d d=%h exp 0 %0d %h",
               RegWrite, WriteRegister, WriteData, m_last_addr, m_last_data);
    end
    for (int i = 0; i < NREQ; i++) begin
      checks++;
      if (rf[i+1] !== DW'(32'hA0 + i)) begin
        failures++;
        $display("FAIL all_rf_%0d: got %h exp %h", i + 1, rf[i+1], 32'hA0 + i);
      end
    end
  endtask

  task automatic test_wrap;
    int exp_seq [3] = '{2, 0, 2};
    int g;
    Req = 4'b0010;
    set_req(1, 5'd2, 32'hB1);
    #1;
    g = model_pick(Req, m_ptr);
    checks++;
    if (Grant !== 4'b0010 || g != 1) begin
      failures++;
      $display("FAIL wrap_g1: got %b exp 0010", Grant);
    end
    m_ptr = 2;
    tick;
    Req = 4'b0101;
    set_req(0, 5'd3, 32'hC0);
    set_req(2, 5'd6, 32'hC2);
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++;
      if (Grant !== onehot(exp_seq[n])) begin
        failures++;
        $display("FAIL wrap_grant_%0d: got %b exp %b", n, Grant, onehot(exp_seq[n]));
      end
      m_ptr = (exp_seq[n] + 1) % NREQ;
      tick;
      checks++;
      if (RegWrite !== 1'b1 ||
          WriteRegister !== ((exp_seq[n] == 0) ? 5'd3 : 5'd6)) begin
        failures++;
        $display("FAIL wrap_write_%0d: got we=%b a=%0d exp 1 %0d",
                 n, RegWrite, WriteRegister, (exp_seq[n] == 0) ? 3 : 6);
      end
    end
    m_last_addr = 5'd6; m_last_data = 32'hC2;
    Req = '0;
    tick;
  endtask

  task automatic test_zero_protect;
    Req = 4'b0001;
    set_req(0, 5'd0, 32'hDEADBEEF);
    #1;
    checks++;
    if (Grant !== 4'b0001) begin
      failures++;
      $display("FAIL zp_grant0: got %b exp 0001", Grant);
    end
    m_ptr = 1;
    tick;
    Req = '0;
    checks++;
    if (RegWrite !== 1'b0 || WriteRegister !== m_last_addr) begin
      failures++;
      $display("FAIL zp_suppress: got we=%b a=%0d exp 0 %0d",
               RegWrite, WriteRegister, m_last_addr);
    end
    tick;
    checks++;
    if (rf[0] !== '0) begin
      failures++;
      $display("FAIL zp_r0: got %h exp 0", rf[0]);
    end
    Req = 4'b0001;
    set_req(0, 5'd5, 32'hDEADBEEF);
    #1;
    checks++;
    if (Grant !== 4'b0001) begin
      failures++;
      $display("FAIL zp_grant5: got %b exp 0001", Grant);
    end
    tick;
    Req = '0;
    checks++;
    if (RegWrite !== 1'b1 || WriteRegister !== 5'd5 || WriteData !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL zp_write5: got we=%b a=%0d d=%h exp 1 5 deadbeef",
               RegWrite, WriteRegister, WriteData);
    end
    m_last_addr = 5'd5; m_last_data = 32'hDEADBEEF;
    tick;
    checks++;
    if (rf[5] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL zp_r5: got %h exp deadbeef", rf[5]);
    end
  endtask

  task automatic test_back_to_back;
    Req = 4'b0100;
    set_req(2, 5'd7, 32'h11111111);
    #1;
    checks++;
    if (Grant !== 4'b0100) begin
      failures++;
      $display("FAIL b2b_g1: got %b exp 0100", Grant);
    end
    m_ptr = 3;
    tick;
    set_req(2, 5'd7, 32'h22222222);
    checks++;
    if (RegWrite !== 1'b1 || WriteRegister !== 5'd7 || WriteData !== 32'h11111111) begin
      failures++;
      $display("FAIL b2b_w1: got we=%b a=%0d d=%h exp 1 7 11111111",
               RegWrite, WriteRegister, WriteData);
    end
    #1;
    checks++;
    if (Grant !== 4'b0100) begin
      failures++;
      $display("FAIL b2b_g2: got %b exp 0100", Grant);
    end
    tick;
    Req = '0;
    checks++;
    if (RegWrite !== 1'b1 || WriteRegister !== 5'd7 || WriteData !== 32'h22222222) begin
      failures++;
      $display("FAIL b2b_w2: got we=%b a=%0d d=%h exp 1 7 22222222",
               RegWrite, WriteRegister, WriteData);
    end
    m_last_addr = 5'd7; m_last_data = 32'h22222222;
    tick;
    checks++;
    if (rf[7] !== 32'h22222222 || RegWrite !== 1'b0) begin
      failures++;
      $display("FAIL b2b_rf: got %h we=%b exp 22222222 0", rf[7], RegWrite);
    end
  endtask

  task automatic test_clear;
    int g;
    int g2;
    Req = 4'b0011;
    set_req(0, 5'd1, 32'h11);
    set_req(1, 5'd2, 32'h22);
    #1;
    g = model_pick(Req, m_ptr);
    checks++;
    if (Grant !== onehot(g)) begin
      failures++;
      $display("FAIL clr_pre_grant: got %b exp %b", Grant, onehot(g));
    end
    m_ptr = (g + 1) % NREQ;
    tick;
    ClearReq = 1'b1;
    #1;
    checks++;
    if (Grant !== '0 || RegWrite !== 1'b1 || WriteRegister !== AW'(g + 1)) begin
      failures++;
      $display("FAIL clr_cycle: got g=%b we=%b a=%0d exp 0 1 %0d",
               Grant, RegWrite, WriteRegister, g + 1);
    end
    tick;
    ClearReq = 1'b0;
    checks++;
    if (RegWrite !== 1'b0 || Busy !== 1'b1 || InitDone !== 1'b0) begin
      failures++;
      $display("FAIL clr_enter: got we=%b b=%b id=%b exp 0 1 0",
               RegWrite, Busy, InitDone);
    end
    g2 = -1;
    for (int k = 0; k < NREGS; k++) begin
      tick;
      checks++;
      if (RegWrite !== 1'b1 || WriteRegister !== AW'(k) || WriteData !== '0) begin
        failures++;
        $display("FAIL clr_sweep_%0d: got we=%b a=%0d d=%h exp 1 %0d 0",
                 k, RegWrite, WriteRegister, WriteData, k);
      end
      checks++;
      if (k < NREGS - 1) begin
        if (Grant !== '0 || Busy !== 1'b1) begin
          failures++;
          $display("FAIL clr_busy_%0d: got g=%b b=%b exp 0 1", k, Grant, Busy);
        end
      end else begin
        g2 = model_pick(Req, m_ptr);
        if (Grant !== onehot(g2)) begin
          failures++;
          $display("FAIL clr_resume_grant: got %b exp %b", Grant, onehot(g2));
        end
        m_ptr = (g2 + 1) % NREQ;
      end
    end
    tick;
    Req = '0;
    checks++;
    if (InitDone !== 1'b1 || Busy !== 1'b0 || RegWrite !== 1'b1 ||
        WriteRegister !== AW'(g2 + 1)) begin
      failures++;
      $display("FAIL clr_resume_write: got id=%b b=%b we=%b a=%0d exp 1 0 1 %0d",
               InitDone, Busy, RegWrite, WriteRegister, g2 + 1);
    end
    for (int a = 0; a < 2**AW; a++) m_rf[a] = '0;
    m_rf[g2 + 1] = (g2 == 0) ? 32'h11 : 32'h22;
    m_last_addr = AW'(g2 + 1);
    m_last_data = m_rf[g2 + 1];
    tick;
  endtask

  task automatic test_random;
    int g;
    logic          exp_we;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    Req = '0;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!Req[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            Req[i] = 1'b1;
            set_req(i, AW'($urandom_range(0, NREGS - 1)), $urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          Req[i] = 1'b0;
        end
      end
      #1;
      g = model_pick(Req, m_ptr);
      checks++;
      if (Grant !== onehot(g)) begin
        failures++;
        $display("FAIL rnd_grant_%0d: got %b exp %b", n, Grant, onehot(g));
      end
      exp_we = 1'b0; ea = '0; ed = '0;
      if (g >= 0) begin
        ea = ReqAddr[g*AW +: AW];
        ed = ReqData[g*DW +: DW];
        exp_we = (ea != '0);
        m_ptr = (g + 1) % NREQ;
      end
      tick;
      if (g >= 0) Req[g] = 1'b0;
      if (exp_we) begin
        m_last_addr = ea; m_last_data = ed;
        m_rf[ea] = ed;
      end
      checks++;
      if (RegWrite !== exp_we || WriteRegister !== m_last_addr ||
          WriteData !== m_last_data) begin
        failures++;
        $display("FAIL rnd_out_%0d: got we=%b a=%0d d=%h exp %b %0d %h",
                 n, RegWrite, WriteRegister, WriteData,
                 exp_we, m_last_addr, m_last_data);
      end
    end
    Req = '0;
    tick;
    for (int a = 0; a < NREGS; a++) begin
      checks++;
      if (rf[a] !== m_rf[a]) begin
        failures++;
        $display("FAIL rnd_rf_%0d: got %h exp %h", a, rf[a], m_rf[a]);
      end
    end
  endtask

  task automatic test_reset_mid;
    Req = '0;
    @(negedge Clk);
    Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick;
      checks++;
      if (RegWrite !== 1'b1 || WriteRegister !== AW'(k)) begin
        failures++;
        $display("FAIL mid_pre_%0d: got we=%b a=%0d exp 1 %0d",
                 k, RegWrite, WriteRegister, k);
      end
    end
    #2;
    Rst_n = 1'b0;
    #1;
    checks++;
    if (RegWrite !== 1'b0 || WriteRegister !== '0 || WriteData !== '0 ||
        Busy !== 1'b1 || InitDone !== 1'b0 || Grant !== '0) begin
      failures++;
      $display("FAIL mid_async: got we=%b a=%0d d=%h b=%b id=%b g=%b exp 0 0 0 1 0 0",
               RegWrite, WriteRegister, WriteData, Busy, InitDone, Grant);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int k = 0; k < NREGS; k++) begin
      tick;
      checks++;
      if (RegWrite !== 1'b1 || WriteRegister !== AW'(k) || WriteData !== '0) begin
        failures++;
        $display("FAIL mid_sweep_%0d: got we=%b a=%0d d=%h exp 1 %0d 0",
                 k, RegWrite, WriteRegister, WriteData, k);
      end
    end
    tick;
    m_ptr = 0;
    Req = '1;
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), DW'(i));
    #1;
    checks++;
    if (InitDone !== 1'b1 || Grant !== onehot(model_pick(Req, m_ptr))) begin
      failures++;
      $display("FAIL mid_ptr_reset: got id=%b g=%b exp 1 %b",
               InitDone, Grant, onehot(model_pick(Req, m_ptr)));
    end
    Req = '0;
    tick;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset;
    test_all_req;
    test_wrap;
    test_zero_protect;
    test_back_to_back;
    test_clear;
    test_random;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
